// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Byte-stream program loader; writes little-endian words into
//            program memory and holds the CPU until the image is complete.
//            Optional checksum stage enabled by macro LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM  = 3'd7,
`endif
      S_ERR   = 3'd6
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CSUM;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t      state;
   state_t      next_state;
   logic [7:0]  len_lo;
   logic [15:0] n_words;
   logic [1:0]  byte_idx;
   logic [15:0] len_word;
   logic        xfer;
   logic        restart;
   logic        last_word;
   logic        too_long;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign xfer      = byte_valid & byte_ready;
   assign len_word  = {byte_in, len_lo};
   assign restart   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
   assign last_word = ({1'b0, word_count} + 17'd1) >= {1'b0, n_words};
   assign too_long  = {16'd0, len_word} > MAX_WORDS;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_LEN0;
         S_LEN0:  if (xfer) next_state = S_LEN1;
         S_LEN1: begin
            if (xfer) begin
               if (len_word == 16'd0) next_state = S_TAIL;
               else if (too_long)     next_state = S_ERR;
               else                   next_state = S_DATA;
            end
         end
         S_DATA:  if (xfer && byte_idx == 2'd3) next_state = S_WRITE;
         S_WRITE: next_state = last_word ? S_TAIL : S_DATA;
`ifdef LOADER_CHECKSUM_EN
         S_CSUM:  if (xfer) next_state = (byte_in == csum) ? S_DONE : S_ERR;
`endif
         S_DONE, S_ERR: if (start) next_state = S_LEN0;
         default: next_state = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_ready <= 1'b0;
         mem_write  <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         byte_ready <= (next_state == S_LEN0) | (next_state == S_LEN1) |
`ifdef LOADER_CHECKSUM_EN
                       (next_state == S_CSUM) |
`endif
                       (next_state == S_DATA);
         mem_write  <= (next_state == S_WRITE);
         cpu_hold   <= (next_state != S_DONE);
         done       <= (next_state == S_DONE);
         error      <= (next_state == S_ERR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_lo         <= 8'd0;
         n_words        <= 16'd0;
         byte_idx       <= 2'd0;
         word_count     <= 16'd0;
         mem_address    <= BASE_ADDR;
         mem_write_data <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum           <= 8'd0;
`endif
      end else begin
         if (restart) begin
            word_count <= 16'd0;
            byte_idx   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
         end
         if (state == S_LEN0 && xfer) len_lo  <= byte_in;
         if (state == S_LEN1 && xfer) n_words <= len_word;
         if (state == S_DATA && xfer) begin
            mem_write_data[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_in;
`endif
            if (byte_idx == 2'd3) begin
               mem_address <= BASE_ADDR + {14'd0, word_count, 2'b00};
            end
         end
         if (state == S_WRITE) word_count <= word_count + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Writer side of the program-memory interface. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into `ProgramMemory` at consecutive word addresses (step 4). The CPU is held in reset until a complete, checksum-verified image has been written.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word
- MAX_WORDS, 256, largest image accepted (in words)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_in  in  8  stream data
- byte_valid  in  1  stream data valid
- byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready at a rising edge
- mem_address  out  32  program-memory byte address
- mem_write_data  out  32  assembled instruction word
- mem_write  out  1  one-cycle write strobe
- cpu_hold  out  1  drives the CPU reset; high = CPU held
- done  out  1  image loaded and verified; level
- error  out  1  load failed; level
- word_count  out  16  words written so far in the current load

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: byte_ready=0. start moves to LEN0, clears word_count, checksum, done and error.
- LEN0 / LEN1: accept the length low byte, then the high byte, giving N words.
  - N=0: go to CSUM.
  - N>MAX_WORDS: go to ERR immediately after the LEN1 byte; no writes occur.
  - Otherwise: go to DATA.
- DATA: accept bytes into a 2-bit byte index. Byte k fills bits [8k+7:8k]. On the 4th byte, go to WRITE.
- WRITE: byte_ready=0 and mem_write=1 for exactly one cycle.
  - mem_address = BASE_ADDR + 4*word_count; word_count increments at the end of the cycle.
  - Next state: DATA if word_count+1 < N, else CSUM.
- CSUM: accept one byte and compare it with the running XOR of all data bytes (length bytes excluded). Match goes to DONE, mismatch goes to ERR.
- DONE: done=1, cpu_hold=0. ERR: error=1, cpu_hold=1.
- start in DONE or ERR restarts at LEN0 and re-asserts cpu_hold the next cycle. start in any other state is ignored.
- byte_valid is ignored whenever byte_ready=0. Bytes are never dropped or duplicated.
- Address arithmetic is 32-bit modulo. word_count is 16-bit and never exceeds MAX_WORDS.

## Timing
- Reset values:
  - state=IDLE, cpu_hold=1, byte_ready=0, mem_write=0, done=0, error=0
  - mem_address=BASE_ADDR, mem_write_data=0, word_count=0
- byte_ready is registered and depends only on state.
- mem_write asserts in the cycle after the 4th byte of a word is accepted. Address and data are stable while mem_write=1.
- Minimum cost per word is 5 cycles (4 transfers plus 1 WRITE cycle).
- done and cpu_hold change together, one cycle after the accepted checksum byte.
- Asserting reset mid-load aborts immediately to the reset values.
  - Any partially assembled word is discarded.
  - A word already strobed stays in memory.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined: CSUM state present, behaving as described above.
- Undefined:
  - CSUM state and XOR logic removed.
  - The last WRITE, or LEN1 with N=0, goes directly to DONE.
  - ERR is reachable only through the N>MAX_WORDS check.

## Test plan
- Reset mid-DATA (after 2 bytes of word 1) -> all outputs at reset values, cpu_hold=1. A following start with a 1-word image loads correctly at BASE_ADDR.
- start, then length 0x0002, then bytes 13 00 00 00 37 02 00 00 and checksum 0x26 -> two writes: 0x00000013 at address 0x0, then 0x00000237 at address 0x4. After that, done=1, cpu_hold=0, word_count=2.
- Same image with checksum 0x27 -> both writes still occur, then error=1, done=0, cpu_hold=1.
- Length 0x0101 with MAX_WORDS=256 -> ERR after the second length byte, mem_write never asserts, byte_ready=0.
- byte_valid toggled randomly with gaps of 0-3 cycles, 8-word image -> memory contents identical to the gap-free case, with exactly 8 single-cycle mem_write pulses.
- Build without LOADER_CHECKSUM_EN, 1-word image 0xDEADBEEF (bytes EF BE AD DE) -> write at BASE_ADDR, then done=1 the next cycle, with no checksum byte consumed.
